// File: rtl/pc_pkg.sv
// Shared command encoding, priority decode and default parameters for pc_ras.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEF        = 32;
    localparam int unsigned PC_STEP_DEF         = 4;
    localparam int unsigned PC_RESET_VECTOR_DEF = 0;
    localparam int unsigned RAS_DEPTH_DEF       = 8;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_BRANCH,
        CMD_JUMP,
        CMD_CALL,
        CMD_RET
    } cmd_e;

    // Stall dominates and maps to HOLD; otherwise ret > call > jump > branch > inc.
    function automatic cmd_e decode_cmd(
        input logic stall,
        input logic ret,
        input logic call,
        input logic jump,
        input logic branch,
        input logic inc
    );
        if (stall)       return CMD_HOLD;
        else if (ret)    return CMD_RET;
        else if (call)   return CMD_CALL;
        else if (jump)   return CMD_JUMP;
        else if (branch) return CMD_BRANCH;
        else if (inc)    return CMD_INC;
        else             return CMD_HOLD;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular LIFO for return addresses; a push when full overwrites the oldest entry.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH_DEF,
    parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_ptr;

    // The pointer wraps naturally, so a push on a full stack lands on the oldest slot.
    assign w_wr_ptr = r_top + PTR_W'(1);
    assign top      = r_mem[r_top];
    assign empty    = (r_count == '0);
    assign full     = (r_count == CNT_W'(DEPTH));

    // Entry storage; contents are never reset and are only read while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_ptr] <= din;
        end
    end

    // Top pointer and occupancy count; count saturates at DEPTH on overwrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top   <= '1;
            r_count <= '0;
        end else if (push) begin
            r_top <= w_wr_ptr;
            if (!full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            r_top   <= r_top - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_ras.sv
// Program counter with integrated return-address stack for the fetch front end.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH        = PC_WIDTH_DEF,
    parameter int unsigned     STEP         = PC_STEP_DEF,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEF),
    parameter int unsigned     RAS_DEPTH    = RAS_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             inc,
    input  logic             jump,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_udf
);

    logic [WIDTH-1:0] r_pc;
    logic             r_ovf;
    logic             r_udf;

    cmd_e             w_cmd;
    logic [WIDTH-1:0] w_ret_addr;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_top;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;

    assign w_cmd      = decode_cmd(stall, ret, call, jump, branch, inc);
    assign w_ret_addr = r_pc + WIDTH'(STEP);
    assign w_push     = (w_cmd == CMD_CALL);
    assign w_pop      = (w_cmd == CMD_RET) && !w_empty;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_ret_addr),
        .top   (w_top),
        .empty (w_empty),
        .full  (w_full)
    );

    // Next-PC selection from the decoded command; a ret on an empty stack holds.
    always_comb begin
        w_next_pc = r_pc;
        unique case (w_cmd)
            CMD_INC:    w_next_pc = w_ret_addr;
            CMD_BRANCH: w_next_pc = r_pc + offset;
            CMD_JUMP:   w_next_pc = target;
            CMD_CALL:   w_next_pc = target;
            CMD_RET:    w_next_pc = w_empty ? r_pc : w_top;
            default:    w_next_pc = r_pc;
        endcase
    end

    // PC register and sticky overflow/underflow flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_VECTOR;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_cmd == CMD_CALL && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_cmd == CMD_RET && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign pc        = r_pc;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_udf   = r_udf;

endmodule

// File: tb/tb_pc_ras.sv
// Self-checking bench for pc_ras: queue-based reference model plus directed and random stimulus.
module tb_pc_ras;

    localparam int unsigned W     = 32;
    localparam int unsigned STEP  = 4;
    localparam int unsigned DEPTH = 4;

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic         stall  = 1'b0;
    logic         inc    = 1'b0;
    logic         jump   = 1'b0;
    logic         branch = 1'b0;
    logic         call   = 1'b0;
    logic         ret    = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] offset = '0;
    logic [W-1:0] pc;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_ovf;
    logic         ras_udf;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stk[$];
    logic         m_ovf;
    logic         m_udf;

    pc_ras #(
        .WIDTH        (W),
        .STEP         (STEP),
        .RESET_VECTOR (32'h0000_0000),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .inc       (inc),
        .jump      (jump),
        .branch    (branch),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .offset    (offset),
        .pc        (pc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_udf   (ras_udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Applies one clock edge of the specified behaviour using the current inputs.
    task automatic model_step();
        if (stall) begin
            // everything holds
        end else if (ret) begin
            if (m_stk.size() == 0) m_udf = 1'b1;
            else                   m_pc = m_stk.pop_back();
        end else if (call) begin
            if (m_stk.size() == DEPTH) begin
                void'(m_stk.pop_front());
                m_ovf = 1'b1;
            end
            m_stk.push_back(m_pc + STEP);
            m_pc = target;
        end else if (jump) begin
            m_pc = target;
        end else if (branch) begin
            m_pc = m_pc + offset;
        end else if (inc) begin
            m_pc = m_pc + STEP;
        end
    endtask

    // Drive one command for one cycle; returns just after the following falling edge.
    task automatic cyc(input bit s, input bit r, input bit c, input bit j, input bit b, input bit i,
                       input logic [W-1:0] t, input logic [W-1:0] o);
        stall = s; ret = r; call = c; jump = j; branch = b; inc = i;
        target = t; offset = o;
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
    endtask

    // Issue a call, then assert reset shortly after the edge and release it at the falling edge.
    task automatic areset_mid(input logic [W-1:0] t);
        stall = 0; ret = 0; call = 1; jump = 0; branch = 0; inc = 0; target = t;
        @(posedge clk);
        if (reset) model_step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_empty", ras_empty, 1);
        chk("async_rst_full", ras_full, 0);
        chk("async_rst_ovf", ras_ovf, 0);
        chk("async_rst_udf", ras_udf, 0);
        call = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Compare DUT against the model every falling edge.
    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("ras_empty", ras_empty, m_stk.size() == 0);
        chk("ras_full", ras_full, m_stk.size() == DEPTH);
        chk("ras_ovf", ras_ovf, m_ovf);
        chk("ras_udf", ras_udf, m_udf);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();

        // Reset then increment
        cyc(0, 0, 0, 0, 0, 1, '0, '0);
        cyc(0, 0, 0, 0, 0, 1, '0, '0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_empty", ras_empty, 1);
        chk("rst_ovf", ras_ovf, 0);
        chk("rst_udf", ras_udf, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 1, '0, '0);
        chk("inc1", pc, 32'd4);
        cyc(0, 0, 0, 0, 0, 1, '0, '0);
        chk("inc2", pc, 32'd8);
        cyc(0, 0, 0, 0, 0, 1, '0, '0);
        chk("inc3", pc, 32'd12);

        // Jump, increment, negative branch
        cyc(0, 0, 0, 1, 0, 0, 32'd132, '0);
        chk("jump", pc, 32'd132);
        cyc(0, 0, 0, 0, 0, 1, '0, '0);
        chk("jump_inc", pc, 32'd136);
        cyc(0, 0, 0, 0, 1, 0, '0, -32'sd8);
        chk("branch_neg", pc, 32'd128);

        // Call and return
        cyc(0, 0, 0, 1, 0, 0, 32'h40, '0);
        cyc(0, 0, 1, 0, 0, 0, 32'h200, '0);
        chk("call_pc", pc, 32'h200);
        chk("call_empty", ras_empty, 0);
        cyc(0, 1, 0, 0, 0, 0, '0, '0);
        chk("ret_pc", pc, 32'h44);
        chk("ret_empty", ras_empty, 1);

        // Overflow then underflow
        cyc(0, 0, 0, 1, 0, 0, 32'h10, '0);
        for (int unsigned k = 1; k <= 5; k++) begin
            cyc(0, 0, 1, 0, 0, 0, 32'(k * 32'h100), '0);
        end
        chk("ovf_full", ras_full, 1);
        chk("ovf_flag", ras_ovf, 1);
        chk("ovf_pc", pc, 32'h500);
        cyc(0, 1, 0, 0, 0, 0, '0, '0);
        chk("pop1", pc, 32'h404);
        cyc(0, 1, 0, 0, 0, 0, '0, '0);
        chk("pop2", pc, 32'h304);
        cyc(0, 1, 0, 0, 0, 0, '0, '0);
        chk("pop3", pc, 32'h204);
        cyc(0, 1, 0, 0, 0, 0, '0, '0);
        chk("pop4", pc, 32'h104);
        chk("pop4_udf", ras_udf, 0);
        cyc(0, 1, 0, 0, 0, 0, '0, '0);
        chk("udf_hold", pc, 32'h104);
        chk("udf_flag", ras_udf, 1);

        // Wrap-around and priority
        cyc(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, '0);
        cyc(0, 0, 0, 0, 0, 1, '0, '0);
        chk("wrap", pc, 32'h0);
        cyc(0, 0, 0, 1, 1, 1, 32'h80, 32'h1000);
        chk("prio_jump", pc, 32'h80);
        cyc(0, 1, 1, 0, 0, 0, 32'h999, '0);
        chk("prio_ret_pc", pc, 32'h80);
        chk("prio_ret_empty", ras_empty, 1);
        chk("prio_ret_udf", ras_udf, 1);

        // Stall with call asserted, then asynchronous reset mid-call
        cyc(0, 0, 1, 0, 0, 0, 32'h300, '0);
        for (int unsigned k = 0; k < 3; k++) begin
            cyc(1, 0, 1, 0, 0, 1, 32'h777, '0);
            chk("stall_pc", pc, 32'h300);
            chk("stall_empty", ras_empty, 0);
            chk("stall_full", ras_full, 0);
        end
        cyc(0, 1, 0, 0, 0, 0, '0, '0);
        chk("stall_ret", pc, 32'h84);
        areset_mid(32'h700);
        cyc(0, 0, 0, 0, 0, 1, '0, '0);
        chk("post_rst_inc", pc, 32'd4);

        // Randomised commands with occasional mid-cycle resets
        for (int unsigned n = 0; n < 600; n++) begin
            logic [W-1:0] t;
            logic [W-1:0] o;
            t = $urandom() & 32'hFFFF_FFFC;
            o = 32'($urandom_range(0, 1023)) - 32'd512;
            if ($urandom_range(0, 79) == 0) begin
                areset_mid(t);
            end else begin
                cyc($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 0, t, o);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
